mux_rr_arbiter: RTL and testbench

- Round-robin arbiter that shares one 4:1 data multiplexer (inputs a, b, c, d; selects s1, s0; output f) between four requesters.
- Registers the grant and drives the select lines. Registers the selected data onto f with a valid flag.
- Limits each grant to MAX_HOLD cycles so that no requester starves the others.
- Sits between four lab-board sources and a single shared output channel.

---
 rtl/mux_rr_arbiter_if.sv | 15 +
 rtl/mux_rr_arbiter.sv | 96 +++++++++
 tb/tb_mux_rr_arbiter.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/mux_rr_arbiter_if.sv
// mux_rr_arbiter_if: request/data/grant bundle between four sources and the arbiter.
// Ports (via modports):
//   master - drives req, a, b, c, d; observes gnt, s1, s0, f, f_valid, busy
//   slave  - the arbiter side; the reverse directions
interface mux_rr_arbiter_if #(parameter int W = 1);
  logic [3:0]   req;
  logic [W-1:0] a, b, c, d;
  logic [3:0]   gnt;
  logic         s1, s0;
  logic [W-1:0] f;
  logic         f_valid;
  logic         busy;
  modport master(output req, a, b, c, d, input gnt, s1, s0, f, f_valid, busy);
  modport slave(input req, a, b, c, d, output gnt, s1, s0, f, f_valid, busy);
endinterface

// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter: round-robin arbiter sharing one 4:1 mux between four requesters.
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   bus   - mux_rr_arbiter_if.slave: req[3:0], a/b/c/d data in;
//           gnt (one-hot), s1/s0 (select), f/f_valid (registered mux out), busy
// Optional: define ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of rotation.
module mux_rr_arbiter #(
  parameter int W        = 1,
  parameter int MAX_HOLD = 4,
  parameter int HCW      = 8
) (
  input logic            clk,
  input logic            rst_n,
  mux_rr_arbiter_if.slave bus
);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t         state, state_nxt;
  logic [1:0]     sel, sel_nxt, win;
  logic [3:0]     gnt, gnt_nxt;
  logic [HCW-1:0] hold_cnt, hold_nxt;
  logic [W-1:0]   f, mux;
  logic           f_valid, rel;
`ifdef ARB_FIXED_PRIO_EN
  always_comb win = bus.req[0] ? 2'd0 : bus.req[1] ? 2'd1 : bus.req[2] ? 2'd2 : 2'd3;
`else
  logic [1:0] ptr, ptr_nxt;
  logic [7:0] dbl;
  logic [3:0] rot;
  // Rotate req so bit 0 is the requester at ptr; the offset of the first set bit
  // added to ptr (mod 4) is the winner.
  always_comb begin
    dbl = {bus.req, bus.req} >> ptr;
    rot = dbl[3:0];
    win = ptr + (rot[0] ? 2'd0 : rot[1] ? 2'd1 : rot[2] ? 2'd2 : 2'd3);
  end
`endif
  // sel always holds the granted index while in GRANT.
  assign rel = !bus.req[sel] || hold_cnt == HCW'(MAX_HOLD);
  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt;
    sel_nxt   = sel;
    hold_nxt  = hold_cnt;
`ifndef ARB_FIXED_PRIO_EN
    ptr_nxt   = ptr;
`endif
    if (state == IDLE) begin
      if (|bus.req) begin
        state_nxt = GRANT;
        gnt_nxt   = 4'b0001 << win;
        sel_nxt   = win;
        hold_nxt  = HCW'(1);
      end
    end else if (rel) begin
      state_nxt = IDLE;
      gnt_nxt   = '0;
      hold_nxt  = '0;
`ifndef ARB_FIXED_PRIO_EN
      ptr_nxt   = sel + 2'd1;
`endif
    end else begin
      hold_nxt = hold_cnt + 1'b1;
    end
  end
  always_comb mux = sel[1] ? (sel[0] ? bus.d : bus.c) : (sel[0] ? bus.b : bus.a);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      gnt      <= '0;
      sel      <= '0;
      hold_cnt <= '0;
      f        <= '0;
      f_valid  <= 1'b0;
`ifndef ARB_FIXED_PRIO_EN
      ptr      <= '0;
`endif
    end else begin
      state    <= state_nxt;
      gnt      <= gnt_nxt;
      sel      <= sel_nxt;
      hold_cnt <= hold_nxt;
      f        <= state == GRANT ? mux : '0;
      f_valid  <= state == GRANT;
`ifndef ARB_FIXED_PRIO_EN
      ptr      <= ptr_nxt;
`endif
    end
  end
  assign bus.gnt     = gnt;
  assign bus.s1      = sel[1];
  assign bus.s0      = sel[0];
  assign bus.f       = f;
  assign bus.f_valid = f_valid;
  assign bus.busy    = state == GRANT;
endmodule

// File: tb/tb_mux_rr_arbiter.sv
// tb_mux_rr_arbiter: directed table-driven check of mux_rr_arbiter (MAX_HOLD=2 and 4 instances).
module tb_mux_rr_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  mux_rr_arbiter_if #(.W(1)) i2 ();
  mux_rr_arbiter_if #(.W(1)) i4 ();
  mux_rr_arbiter #(.W(1), .MAX_HOLD(2), .HCW(8)) u2 (.clk(clk), .rst_n(rst_n), .bus(i2));
  mux_rr_arbiter #(.W(1), .MAX_HOLD(4), .HCW(8)) u4 (.clk(clk), .rst_n(rst_n), .bus(i4));
  typedef struct {
    bit         u;
    bit         rs;
    logic [3:0] req;
    logic [3:0] dat;
    logic [3:0] g;
    logic [1:0] s;
    logic       f;
    logic       fv;
  } vec_t;
  vec_t tv[$];
  task automatic add(input bit u, input bit rs, input logic [3:0] req, input logic [3:0] dat,
                     input logic [3:0] g, input logic [1:0] s, input logic f, input logic fv);
    vec_t v;
    v.u = u; v.rs = rs; v.req = req; v.dat = dat; v.g = g; v.s = s; v.f = f; v.fv = fv;
    tv.push_back(v);
  endtask
  task automatic chk(input string nm, input logic [8:0] act, input logic [8:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: {gnt,s1,s0,f,f_valid,busy} got %b expected %b", nm, act, exp);
    end
  endtask
  function automatic logic [8:0] obs4();
    return {i4.gnt, i4.s1, i4.s0, i4.f, i4.f_valid, i4.busy};
  endfunction
  function automatic logic [8:0] obs2();
    return {i2.gnt, i2.s1, i2.s0, i2.f, i2.f_valid, i2.busy};
  endfunction
  task automatic idle_inputs();
    i2.req = '0; i2.a = '0; i2.b = '0; i2.c = '0; i2.d = '0;
    i4.req = '0; i4.a = '0; i4.b = '0; i4.c = '0; i4.d = '0;
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  initial begin
    idle_inputs();
    // single request to b, MAX_HOLD=4
    add(1, 1, 4'b0010, 4'b0010, 4'b0010, 2'b01, 0, 0);
    add(1, 0, 4'b0010, 4'b0010, 4'b0010, 2'b01, 1, 1);
    add(1, 0, 4'b0010, 4'b0010, 4'b0010, 2'b01, 1, 1);
    add(1, 0, 4'b0010, 4'b0010, 4'b0010, 2'b01, 1, 1);
    add(1, 0, 4'b0010, 4'b0010, 4'b0000, 2'b01, 1, 1);
    add(1, 0, 4'b0010, 4'b0010, 4'b0010, 2'b01, 0, 0);
    add(1, 0, 4'b0010, 4'b0010, 4'b0010, 2'b01, 1, 1);
`ifndef ARB_FIXED_PRIO_EN
    // all requesting, MAX_HOLD=2; data {d,c,b,a}=1101
    add(0, 1, 4'b1111, 4'b1101, 4'b0001, 2'b00, 0, 0);
    add(0, 0, 4'b1111, 4'b1101, 4'b0001, 2'b00, 1, 1);
    add(0, 0, 4'b1111, 4'b1101, 4'b0000, 2'b00, 1, 1);
    add(0, 0, 4'b1111, 4'b1101, 4'b0010, 2'b01, 0, 0);
    add(0, 0, 4'b1111, 4'b1101, 4'b0010, 2'b01, 0, 1);
    add(0, 0, 4'b1111, 4'b1101, 4'b0000, 2'b01, 0, 1);
    add(0, 0, 4'b1111, 4'b1101, 4'b0100, 2'b10, 0, 0);
    add(0, 0, 4'b1111, 4'b1101, 4'b0100, 2'b10, 1, 1);
    add(0, 0, 4'b1111, 4'b1101, 4'b0000, 2'b10, 1, 1);
    add(0, 0, 4'b1111, 4'b1101, 4'b1000, 2'b11, 0, 0);
    add(0, 0, 4'b1111, 4'b1101, 4'b1000, 2'b11, 1, 1);
    add(0, 0, 4'b1111, 4'b1101, 4'b0000, 2'b11, 1, 1);
    add(0, 0, 4'b1111, 4'b1101, 4'b0001, 2'b00, 0, 0);
    // early drop of req[0]; re-raising req[0] proves ptr moved to 1
    add(1, 1, 4'b0101, 4'b0001, 4'b0001, 2'b00, 0, 0);
    add(1, 0, 4'b0100, 4'b0001, 4'b0000, 2'b00, 1, 1);
    add(1, 0, 4'b0101, 4'b0001, 4'b0100, 2'b10, 0, 0);
    // wrap: ptr reaches 3, grant d then a
    add(1, 1, 4'b0100, 4'b0101, 4'b0100, 2'b10, 0, 0);
    add(1, 0, 4'b1001, 4'b0101, 4'b0000, 2'b10, 1, 1);
    add(1, 0, 4'b1001, 4'b0101, 4'b1000, 2'b11, 0, 0);
    add(1, 0, 4'b1001, 4'b0101, 4'b1000, 2'b11, 0, 1);
    add(1, 0, 4'b1001, 4'b0101, 4'b1000, 2'b11, 0, 1);
    add(1, 0, 4'b1001, 4'b0101, 4'b1000, 2'b11, 0, 1);
    add(1, 0, 4'b1001, 4'b0101, 4'b0000, 2'b11, 0, 1);
    add(1, 0, 4'b1001, 4'b0101, 4'b0001, 2'b00, 0, 0);
    add(1, 0, 4'b1001, 4'b0101, 4'b0001, 2'b00, 1, 1);
`endif
    // req=1010, MAX_HOLD=2; data b=1, d=0
    add(0, 1, 4'b1010, 4'b0010, 4'b0010, 2'b01, 0, 0);
    add(0, 0, 4'b1010, 4'b0010, 4'b0010, 2'b01, 1, 1);
    add(0, 0, 4'b1010, 4'b0010, 4'b0000, 2'b01, 1, 1);
`ifdef ARB_FIXED_PRIO_EN
    add(0, 0, 4'b1010, 4'b0010, 4'b0010, 2'b01, 0, 0);
    add(0, 0, 4'b1010, 4'b0010, 4'b0010, 2'b01, 1, 1);
    add(0, 0, 4'b1010, 4'b0010, 4'b0000, 2'b01, 1, 1);
`else
    add(0, 0, 4'b1010, 4'b0010, 4'b1000, 2'b11, 0, 0);
    add(0, 0, 4'b1010, 4'b0010, 4'b1000, 2'b11, 0, 1);
    add(0, 0, 4'b1010, 4'b0010, 4'b0000, 2'b11, 0, 1);
`endif
    add(0, 0, 4'b1010, 4'b0010, 4'b0010, 2'b01, 0, 0);
    // reset state
    @(negedge clk);
    chk("reset_u2", obs2(), 9'b0);
    chk("reset_u4", obs4(), 9'b0);
    rst_n = 1'b1;
    foreach (tv[i]) begin
      if (tv[i].rs) do_reset();
      if (tv[i].u) begin
        i4.req = tv[i].req;
        {i4.d, i4.c, i4.b, i4.a} = tv[i].dat;
      end else begin
        i2.req = tv[i].req;
        {i2.d, i2.c, i2.b, i2.a} = tv[i].dat;
      end
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d", i), tv[i].u ? obs4() : obs2(),
          {tv[i].g, tv[i].s, tv[i].f, tv[i].fv, |tv[i].g});
    end
    // asynchronous reset in the middle of a grant to c
    do_reset();
    i4.req = 4'b0100;
    i4.c = 1'b1;
    @(posedge clk);
    #1;
    chk("pre_abort_grant", obs4(), {4'b0100, 2'b10, 1'b0, 1'b0, 1'b1});
    @(posedge clk);
    #1;
    chk("pre_abort_data", obs4(), {4'b0100, 2'b10, 1'b1, 1'b1, 1'b1});
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_abort", obs4(), 9'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("regrant_after_reset", obs4(), {4'b0100, 2'b10, 1'b0, 1'b0, 1'b1});
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
